lsu_bus_ctrl: RTL and testbench
===============================

// Module: lsu_bus_ctrl
// PURPOSE
//  Parametrised load/store controller between the execute stage and the data-memory bus.
//  Decodes RV32 load/store instrs (opcodes pkg), drives a DATA_W-wide word bus with byte lanes.
//  Extends the single-beat memory controller with: valid/ready issue, wider buses, ack timeout,
//  and optional split of misaligned accesses.
// PARAMETERS
//  DATA_W          32  bus data width, 32 or 64; BYTES=DATA_W/8, OFS_W=log2(BYTES)
//  ADDR_W          32  word-address width on the bus
//  TIMEOUT_CYCLES  16  max cycles waiting for ack before error; 0 = wait forever
// PORTS
//  clk                 in   1        clock, all state on rising edge
//  rst_n               in   1        synchronous reset, active low
//  instr               in   32       instruction_t; only is_memory_op() instrs are accepted
//  op1, op2            in   32       base, offset; byte address EA = op1+op2 (mod 2^32)
//  op3                 in   32       store data (rs2)
//  enable              in   1        request valid
//  ready               out  1        controller can accept (state==IDLE)
//  result              out  32       load result, sign/zero-extended; holds until next load done
//  result_valid        out  1        1-cycle pulse: load complete
//  store_done          out  1        1-cycle pulse: store complete
//  error               out  1        1-cycle pulse with completion: misalign (no split) or timeout
//  address             out  ADDR_W   word address = EA >> OFS_W (truncated to ADDR_W)
//  read_enable         out  1        1-cycle read request
//  read_data           in   DATA_W   read data, valid with read_ack
//  read_ack            in   1        read response
//  write_enable        out  1        1-cycle write request
//  write_byte_enable   out  BYTES    lane strobes
//  write_data          out  DATA_W   lane-aligned store data
//  write_ack           in   1        write response
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; every output 0 except ready=1; result=0; counters cleared.
//    Reset mid-transaction abandons it; later acks arriving in IDLE are ignored.
//  - Accept: enable & ready & is_memory_op(instr) -> latch EA, op3, size(1/2/4), sign_ex, ld/st.
//    enable with non-memory instr: ignored, stays IDLE.
//  - FSM: IDLE -> REQ1 -> WAIT1 -> [REQ2 -> WAIT2] -> DONE -> IDLE.
//    REQn: read_enable or write_enable=1 for exactly one cycle, address/strobes/data valid.
//    WAITn: address/strobes/data held; only the ack matching op type counts; acks in REQn ignored.
//    DONE: result_valid (load) or store_done (store) for one cycle; ready=0; -> IDLE.
//  - Min latency: accept at T, req T+1, ack T+2, done pulse T+3; next accept T+4.
//  - Lanes: ofs=EA[OFS_W-1:0]; strobes = ((1<<size)-1) << ofs; write_data = op3 << (8*ofs).
//    Load: bytes extracted from lane ofs, sign-extended from bit 8*size-1 if LB/LH, else zero.
//  - Misaligned: ofs+size > BYTES. Handling depends on LSU_SPLIT_MISALIGN_EN (below).
//  - Timeout: counter cleared on entering WAITn, +1 per WAIT cycle; reaching TIMEOUT_CYCLES
//    without ack -> DONE with error=1, no result_valid/store_done, result unchanged.
//  - Register state only; result register written only on successful load completion.
//  - Word address wrap: second beat address = address+1 mod 2^ADDR_W.
// CONFIGURATION
//  LSU_SPLIT_MISALIGN_EN defined: misaligned access runs two beats. Beat1 at word A, lanes
//    ofs..BYTES-1; beat2 at A+1, lanes 0..(ofs+size-BYTES-1). Load assembled low bytes from
//    beat1, high from beat2. Timeout applies per beat; timeout in beat2 after a store beat1
//    still reports error (partial write is not rolled back).
//  Undefined: misaligned access skips REQ/WAIT: IDLE -> DONE with error=1, no bus activity.
// TESTING
//  1 DATA_W=32: LW EA=0x100, read_data=0xDEADBEEF ack 1 cycle later -> address=0x40,
//    read_enable 1 cycle, result=0xDEADBEEF, result_valid at T+3.
//  2 LB EA=0x103, read_data=0x80123456 -> result=0xFFFFFF80; LBU same -> 0x00000080.
//  3 SH EA=0x102 op3=0x0000ABCD -> write_byte_enable=4'b1100, write_data=0xABCD0000,
//    store_done 1 cycle after write_ack; DATA_W=64 SB EA=0x7 -> strobes 8'h80.
//  4 LW EA=0x6 DATA_W=32: with macro -> reads word 1 then 2 (data 0x11223344, 0x55667788)
//    -> result=0x77881122; without macro -> error pulse, read_enable never asserted.
//  5 TIMEOUT_CYCLES=4, no read_ack -> error pulse after 4 WAIT cycles, result unchanged;
//    late read_ack in IDLE ignored.
//  6 rst_n low during WAIT1 -> next cycle ready=1, all other outputs 0; following LW correct.

Source files
------------

// File: rtl/lsu_bus_ctrl_if.sv
// Data-memory bus between the load/store controller and memory.
// Word address, single-cycle requests, lane strobes and ack responses.
interface lsu_bus_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read_enable;
    logic [DATA_W-1:0] read_data;
    logic              read_ack;
    logic              write_enable;
    logic [BYTES-1:0]  write_byte_enable;
    logic [DATA_W-1:0] write_data;
    logic              write_ack;

    modport master (
        output address, read_enable, write_enable,
        output write_byte_enable, write_data,
        input  read_data, read_ack, write_ack
    );

    modport slave (
        input  address, read_enable, write_enable,
        input  write_byte_enable, write_data,
        output read_data, read_ack, write_ack
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// RV32 load/store bus controller: valid/ready issue, lane strobes, ack timeout.
// Define LSU_SPLIT_MISALIGN_EN to run misaligned accesses as two bus beats.
module lsu_bus_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] op3,
    input  logic        enable,
    output logic        ready,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        store_done,
    output logic        error,
    lsu_bus_ctrl_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = TIMEOUT_CYCLES != 0;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
`ifdef LSU_SPLIT_MISALIGN_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_DONE
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [OFS_W-1:0] ofs;
    logic [31:0]      wd;
    logic [1:0]       szc;
    logic             sx;
    logic             ld;
    logic             split;
    logic [DATA_W-1:0] lo;

    function automatic logic [2*BYTES-1:0] strb_of(
        input logic [OFS_W-1:0] o, input logic [1:0] c);
        logic [3:0] m;
        m = c == 2'd0 ? 4'b0001 : (c == 2'd1 ? 4'b0011 : 4'b1111);
        return (2*BYTES)'(m) << o;
    endfunction

    function automatic logic [2*DATA_W-1:0] data_of(
        input logic [OFS_W-1:0] o, input logic [31:0] d);
        return (2*DATA_W)'(d) << {o, 3'b000};
    endfunction

    logic [6:0] opc;
    logic [2:0] f3;
    logic       is_ld;
    logic       is_st;
    logic       mem_op;
    logic [31:0] ea_n;
    logic [OFS_W-1:0] ofs_n;
    logic       misal_n;

    assign opc    = instr[6:0];
    assign f3     = instr[14:12];
    assign mem_op = is_ld | is_st;
    assign ea_n   = op1 + op2;
    assign ofs_n  = ea_n[OFS_W-1:0];
    assign misal_n = int'(ofs_n) + (1 << f3[1:0]) > BYTES;

    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        unique case (1'b1)
            opc == OPC_LOAD:
                is_ld = f3[1:0] != 2'b11 && f3 != 3'b110;
            opc == OPC_STORE:
                is_st = !f3[2] && f3[1:0] != 2'b11;
            default: ;
        endcase
    end

    // Beat 1 lanes come from the issue inputs, beat 2 from latched state.
    logic [2*BYTES-1:0]  s1;
    logic [2*BYTES-1:0]  s2;
    logic [2*DATA_W-1:0] d1;
    logic [2*DATA_W-1:0] d2;

    assign s1 = strb_of(ofs_n, f3[1:0]);
    assign d1 = data_of(ofs_n, op3);
    assign s2 = strb_of(ofs, szc);
    assign d2 = data_of(ofs, wd);

    logic [2*DATA_W-1:0] rd2;
    logic [2*DATA_W-1:0] rsh;
    logic [31:0]         w;
    logic [31:0]         ld_val;
    logic                ack_ok;

    assign rd2 = st == S_WAIT2 ? {bus.read_data, lo}
                               : (2*DATA_W)'(bus.read_data);
    assign rsh = rd2 >> {ofs, 3'b000};
    assign w   = rsh[31:0];
    assign ack_ok = ld ? bus.read_ack : bus.write_ack;

    always_comb begin
        ld_val = w;
        unique case (1'b1)
            szc == 2'd0: ld_val = {{24{sx & w[7]}}, w[7:0]};
            szc == 2'd1: ld_val = {{16{sx & w[15]}}, w[15:0]};
            default:     ld_val = w;
        endcase
    end

    wire unused = ^{instr[31:15], instr[11:7], rsh[2*DATA_W-1:32],
                    s1[2*BYTES-1:BYTES], d1[2*DATA_W-1:DATA_W],
                    s2[BYTES-1:0], d2[DATA_W-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st                    <= S_IDLE;
            ready                 <= 1'b1;
            result                <= '0;
            result_valid          <= 1'b0;
            store_done            <= 1'b0;
            error                 <= 1'b0;
            bus.address           <= '0;
            bus.read_enable       <= 1'b0;
            bus.write_enable      <= 1'b0;
            bus.write_byte_enable <= '0;
            bus.write_data        <= '0;
            cnt                   <= '0;
            ofs                   <= '0;
            wd                    <= '0;
            szc                   <= '0;
            sx                    <= 1'b0;
            ld                    <= 1'b0;
            split                 <= 1'b0;
            lo                    <= '0;
        end else begin
            result_valid     <= 1'b0;
            store_done       <= 1'b0;
            error            <= 1'b0;
            bus.read_enable  <= 1'b0;
            bus.write_enable <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (enable && mem_op) begin
                        ofs   <= ofs_n;
                        wd    <= op3;
                        szc   <= f3[1:0];
                        sx    <= ~f3[2];
                        ld    <= is_ld;
                        split <= SPLIT & misal_n;
                        ready <= 1'b0;
                        if (misal_n && !SPLIT) begin
                            st    <= S_DONE;
                            error <= 1'b1;
                        end else begin
                            st                    <= S_REQ1;
                            bus.address           <= ADDR_W'(ea_n >> OFS_W);
                            bus.read_enable       <= is_ld;
                            bus.write_enable      <= is_st;
                            bus.write_byte_enable <= s1[BYTES-1:0];
                            bus.write_data        <= d1[DATA_W-1:0];
                        end
                    end
                end
                S_REQ1: begin
                    st  <= S_WAIT1;
                    cnt <= '0;
                end
                S_REQ2: begin
                    st  <= S_WAIT2;
                    cnt <= '0;
                end
                S_WAIT1, S_WAIT2: begin
                    if (ack_ok) begin
                        if (st == S_WAIT1 && split) begin
                            st                    <= S_REQ2;
                            lo                    <= bus.read_data;
                            bus.address           <= bus.address + ADDR_W'(1);
                            bus.read_enable       <= ld;
                            bus.write_enable      <= ~ld;
                            bus.write_byte_enable <= s2[2*BYTES-1:BYTES];
                            bus.write_data        <= d2[2*DATA_W-1:DATA_W];
                        end else begin
                            st <= S_DONE;
                            if (ld) begin
                                result       <= ld_val;
                                result_valid <= 1'b1;
                            end else begin
                                store_done <= 1'b1;
                            end
                        end
                    end else if (TO_EN && cnt == TO_LAST) begin
                        st    <= S_DONE;
                        error <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    st    <= S_IDLE;
                    ready <= 1'b1;
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed vector table, hand-written corner sequences,
// and random traffic checked against a byte-addressed memory model.
module tb_lsu_bus_ctrl;
    localparam logic [6:0] LD = 7'h03;
    localparam logic [6:0] ST = 7'h23;
`ifdef LSU_SPLIT_MISALIGN_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, op1, op2, op3;
    logic        enable;
    logic        ready;
    logic [31:0] result;
    logic        result_valid, store_done, error;

    always #5 clk = ~clk;

    lsu_bus_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    lsu_bus_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .op1(op1), .op2(op2),
        .op3(op3), .enable(enable), .ready(ready), .result(result),
        .result_valid(result_valid), .store_done(store_done),
        .error(error), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] bus_mem [256];
    logic [7:0] ref_mem [256];
    logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] stf [3] = '{3'd0, 3'd1, 3'd2};

    typedef struct {
        logic [31:0] addr, wd, res;
        logic [3:0]  strb;
        int          beats, lat;
        bit          rv, sd, err, done;
    } obs_t;

    typedef struct {
        logic [31:0] ins, a, b, d, r1, r2, res;
        logic [3:0]  strb;
        logic [31:0] wd, addr;
        bit          err;
        int          beats, lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc,
                                       input logic [2:0] f3);
        return {17'd0, f3, 5'd5, opc};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] ea,
                                             input logic [2:0] f3);
        int n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[8'(ea + 32'(i))]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] ea, input logic [2:0] f3,
                             input logic [31:0] d);
        for (int i = 0; i < (1 << f3[1:0]); i++)
            ref_mem[8'(ea + 32'(i))] = d[8*i +: 8];
    endtask

    // One complete transaction with a memory responder; starts at a negedge.
    task automatic do_txn(input logic [31:0] ins, a, b, d, r1, r2,
                          input int dly, input bit noack, input bit ovr,
                          output obs_t o);
        int g, cnt;
        bit is_rd;
        logic [31:0] ra, rw;
        logic [3:0] rs;
        logic [7:0] bi;
        o = '{default: 0};
        ra = '0; rw = '0; rs = '0; is_rd = 1'b0;
        g = 0;
        while (!ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        instr = ins; op1 = a; op2 = b; op3 = d; enable = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int c = 0; c < 40 && !o.done; c++) begin
            @(negedge clk);
            enable = 1'b0;
            bus.read_ack = 1'b0;
            bus.write_ack = 1'b0;
            o.lat++;
            if (result_valid || store_done || error) begin
                o.done = 1'b1;
                o.rv = result_valid;
                o.sd = store_done;
                o.err = error;
                o.res = result;
            end else if (bus.read_enable || bus.write_enable) begin
                o.beats++;
                is_rd = bus.read_enable;
                ra = bus.address;
                rs = bus.write_byte_enable;
                rw = bus.write_data;
                if (o.beats == 1) begin
                    o.addr = ra; o.strb = rs; o.wd = rw;
                end
                cnt = dly;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !noack) begin
                    bi = 8'(ra << 2);
                    if (is_rd) begin
                        bus.read_data = ovr ? (o.beats == 1 ? r1 : r2) :
                            {bus_mem[8'(bi + 8'd3)], bus_mem[8'(bi + 8'd2)],
                             bus_mem[8'(bi + 8'd1)], bus_mem[bi]};
                        bus.read_ack = 1'b1;
                    end else begin
                        for (int k = 0; k < 4; k++)
                            if (rs[k]) bus_mem[8'(bi + 8'(k))] = rw[8*k +: 8];
                        bus.write_ack = 1'b1;
                    end
                end
            end
        end
        chk("txn_done", 32'(o.done), 32'd1);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ready"}, 32'(ready), 32'd1);
        chk({nm, "_pulses"}, 32'({result_valid, store_done, error,
            bus.read_enable, bus.write_enable}), 32'd0);
        chk({nm, "_result"}, result, 32'd0);
        chk({nm, "_addr"}, bus.address, 32'd0);
        chk({nm, "_bus"}, 32'(bus.write_byte_enable) | bus.write_data, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t        tv [10];
    obs_t        o;
    logic [31:0] last_res, a, b, d, ea, e_res;
    logic [2:0]  f3;
    bit          isld, st, na, mis, e_err;
    int          dly, e_beats;

    initial begin
        rst_n = 1'b0; enable = 1'b0;
        instr = '0; op1 = '0; op2 = '0; op3 = '0;
        bus.read_data = '0; bus.read_ack = 1'b0; bus.write_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        last_res = '0;

        tv[0] = '{mk(LD,2), 32'h100, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF,
                  4'h0, 0, 32'h40, 0, 1, 3};
        tv[1] = '{mk(LD,0), 32'h100, 3, 0, 32'h80123456, 0, 32'hFFFFFF80,
                  4'h0, 0, 32'h40, 0, 1, 3};
        tv[2] = '{mk(LD,4), 32'hFF, 4, 0, 32'h80123456, 0, 32'h00000080,
                  4'h0, 0, 32'h40, 0, 1, 3};
        tv[3] = '{mk(ST,1), 32'h100, 2, 32'h0000ABCD, 0, 0, 0,
                  4'hC, 32'hABCD0000, 32'h40, 0, 1, 3};
        tv[4] = '{mk(LD,2), 0, 6, 0, 32'h11223344, 32'h55667788, 32'h77881122,
                  4'h0, 0, 32'h1, !SPLIT, SPLIT ? 2 : 0, SPLIT ? 5 : 1};
        tv[5] = '{mk(LD,1), 32'h20, 1, 0, 32'h80FF7F00, 0, 32'hFFFFFF7F,
                  4'h0, 0, 32'h8, 0, 1, 3};
        tv[6] = '{mk(LD,5), 32'h20, 2, 0, 32'h80FF7F00, 0, 32'h000080FF,
                  4'h0, 0, 32'h8, 0, 1, 3};
        tv[7] = '{mk(ST,0), 32'h20, 3, 32'h12345678, 0, 0, 0,
                  4'h8, 32'h78000000, 32'h8, 0, 1, 3};
        tv[8] = '{mk(ST,2), 32'hFFFFFFF0, 32'h14, 32'hCAFEF00D, 0, 0, 0,
                  4'hF, 32'hCAFEF00D, 32'h1, 0, 1, 3};
        tv[9] = '{mk(ST,1), 0, 3, 32'h0000ABCD, 0, 0, 0,
                  4'h8, 32'hCD000000, 32'h0, !SPLIT, SPLIT ? 2 : 0, SPLIT ? 5 : 1};

        for (int i = 0; i < 10; i++) begin
            do_txn(tv[i].ins, tv[i].a, tv[i].b, tv[i].d, tv[i].r1, tv[i].r2,
                   1, 1'b0, 1'b1, o);
            isld = tv[i].ins[6:0] == LD;
            e_res = (isld && !tv[i].err) ? tv[i].res : last_res;
            chk($sformatf("t%0d_err", i), 32'(o.err), 32'(tv[i].err));
            chk($sformatf("t%0d_rv", i), 32'(o.rv), 32'(isld && !tv[i].err));
            chk($sformatf("t%0d_sd", i), 32'(o.sd), 32'(!isld && !tv[i].err));
            chk($sformatf("t%0d_beats", i), 32'(o.beats), 32'(tv[i].beats));
            chk($sformatf("t%0d_lat", i), 32'(o.lat), 32'(tv[i].lat));
            chk($sformatf("t%0d_result", i), o.res, e_res);
            if (tv[i].beats > 0)
                chk($sformatf("t%0d_addr", i), o.addr, tv[i].addr);
            if (!isld && tv[i].beats > 0) begin
                chk($sformatf("t%0d_strb", i), 32'(o.strb), 32'(tv[i].strb));
                chk($sformatf("t%0d_wdata", i), o.wd, tv[i].wd);
            end
            last_res = e_res;
        end

        // Timeout with no ack, then stray acks while idle.
        do_txn(mk(LD,2), 32'h40, 0, 0, 0, 0, 1, 1'b1, 1'b1, o);
        chk("to_err", 32'(o.err), 32'd1);
        chk("to_rv", 32'(o.rv), 32'd0);
        chk("to_lat", 32'(o.lat), 32'd6);
        chk("to_beats", 32'(o.beats), 32'd1);
        chk("to_result", o.res, last_res);
        bus.read_ack = 1'b1;
        bus.read_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0)
                chk("late_ack_ready", 32'(ready), 32'd1);
            chk("late_ack_pulses", 32'({result_valid, error,
                bus.read_enable}), 32'd0);
            chk("late_ack_result", result, last_res);
        end
        bus.read_ack = 1'b0;

        // Non-memory instruction is ignored.
        instr = 32'h00500093; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nonmem_ready", 32'(ready), 32'd1);
            chk("nonmem_req", 32'({bus.read_enable, bus.write_enable}), 32'd0);
        end
        enable = 1'b0;

        // Reset during WAIT1, then a clean load.
        instr = mk(LD,2); op1 = 32'h10; op2 = 0; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("midrst");
        last_res = '0;
        do_txn(mk(LD,2), 32'h10, 0, 0, 32'h0BADF00D, 0, 2, 1'b0, 1'b1, o);
        chk("postrst_rv", 32'(o.rv), 32'd1);
        chk("postrst_result", o.res, 32'h0BADF00D);
        chk("postrst_addr", o.addr, 32'h4);
        last_res = 32'h0BADF00D;

        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end

        for (int n = 0; n < 200; n++) begin
            st = $urandom_range(0, 2) == 0;
            f3 = st ? stf[$urandom_range(0, 2)] : ldf[$urandom_range(0, 4)];
            a = 32'($urandom_range(0, 60));
            b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                a = a + 32'hFFFF_FF00;
                b = b + 32'h100;
            end
            ea = a + b;
            d = $urandom;
            dly = $urandom_range(1, 4);
            na = $urandom_range(0, 15) == 0;
            mis = int'(ea[1:0]) + (1 << f3[1:0]) > 4;
            do_txn(mk(st ? ST : LD, f3), a, b, d, 0, 0, dly, na, 1'b0, o);
            e_err = na || (mis && !SPLIT);
            e_beats = (mis && !SPLIT) ? 0 : ((mis && !na) ? 2 : 1);
            if (!st && !e_err) last_res = ref_load(ea, f3);
            if (st && !e_err) ref_store(ea, f3, d);
            chk($sformatf("r%0d_err", n), 32'(o.err), 32'(e_err));
            chk($sformatf("r%0d_rv", n), 32'(o.rv), 32'(!st && !e_err));
            chk($sformatf("r%0d_sd", n), 32'(o.sd), 32'(st && !e_err));
            chk($sformatf("r%0d_beats", n), 32'(o.beats), 32'(e_beats));
            chk($sformatf("r%0d_result", n), o.res, last_res);
        end

        for (int wi = 0; wi < 16; wi++) begin
            do_txn(mk(LD,2), 32'(4 * wi), 0, 0, 0, 0, 1, 1'b0, 1'b0, o);
            chk($sformatf("mem%0d", wi), o.res, ref_load(32'(4 * wi), 3'd2));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
